// File: rtl/i2c_frequency_controller.sv
// I2C prescale controller: preset/custom setting with busy-safe apply.
// Also generates a 5x SCL tick strobe from the active prescale.
module i2c_frequency_controller #(
    parameter int FREQ_SELECTION_BIT_WIDTH = 16,
    parameter int NUM_PRESETS = 4,
    parameter logic [0:NUM_PRESETS-1][FREQ_SELECTION_BIT_WIDTH-1:0] PRESET_VALUES =
        {16'h0095, 16'h0024, 16'h000E, 16'h0003},
    parameter int RESET_PRESET = 0,
    parameter logic [FREQ_SELECTION_BIT_WIDTH-1:0] MIN_SETTING = 16'h0003,
    localparam int SELW = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [SELW-1:0]                     preset_sel_i,
    input  logic                                custom_en_i,
    input  logic [FREQ_SELECTION_BIT_WIDTH-1:0] custom_value_i,
    input  logic                                load_i,
    input  logic                                i2c_busy_i,
    input  logic                                tick_en_i,
    output logic [FREQ_SELECTION_BIT_WIDTH-1:0] frequency_setting_o,
    output logic                                pending_o,
    output logic                                applied_o,
    output logic                                clamped_o,
    output logic                                tick_o
);

    localparam int W = FREQ_SELECTION_BIT_WIDTH;
    localparam logic [W-1:0] RST_RAW = PRESET_VALUES[RESET_PRESET];
    localparam logic RST_CLAMP = (RST_RAW < MIN_SETTING);
    localparam logic [W-1:0] RST_SET = RST_CLAMP ? MIN_SETTING : RST_RAW;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_cand;
    logic           r_cand_clamp;
    logic [W-1:0]   r_setting;
    logic           r_clamped;
    logic           r_applied;
    logic [W-1:0]   r_cnt;
    logic           r_tick;
    logic [W-1:0]   w_raw;
    logic [W-1:0]   w_cand;
    logic           w_cand_clamp;
    logic           w_apply;

    // Out-of-range selects fall back to the reset preset
    always_comb begin
        w_raw = PRESET_VALUES[RESET_PRESET];
        if (custom_en_i)
            w_raw = custom_value_i;
        else if (int'(preset_sel_i) < NUM_PRESETS)
            w_raw = PRESET_VALUES[preset_sel_i];
        w_cand_clamp = (w_raw < MIN_SETTING);
        w_cand       = w_cand_clamp ? MIN_SETTING : w_raw;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (load_i)
                    w_state_nxt = PENDING;
            end
            PENDING: begin
                if (load_i) begin
                    w_state_nxt = PENDING;
                end else if (!i2c_busy_i) begin
                    w_state_nxt = IDLE;
                    w_apply     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_cand       <= RST_SET;
            r_cand_clamp <= RST_CLAMP;
            r_setting    <= RST_SET;
            r_clamped    <= RST_CLAMP;
            r_applied    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_applied <= w_apply;
            if (load_i) begin
                r_cand       <= w_cand;
                r_cand_clamp <= w_cand_clamp;
            end
            if (w_apply) begin
                r_setting <= r_cand;
                r_clamped <= r_cand_clamp;
            end
        end
    end

    // Down-counter; period is setting+1, restarted on every apply
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt  <= RST_SET;
            r_tick <= 1'b0;
        end else if (w_apply) begin
            r_cnt  <= r_cand;
            r_tick <= 1'b0;
        end else if (!tick_en_i) begin
            r_cnt  <= r_setting;
            r_tick <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt  <= r_setting;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign frequency_setting_o = r_setting;
    assign pending_o           = (r_state == PENDING);
    assign applied_o           = r_applied;
    assign clamped_o           = r_clamped;
    assign tick_o              = r_tick;

endmodule

// File: tb/tb_i2c_frequency_controller.sv
// Directed bench for i2c_frequency_controller.
// Hand-computed expected values, one task per scenario.
module tb_i2c_frequency_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  preset_sel;
    logic        custom_en;
    logic [15:0] custom_value;
    logic        load;
    logic        busy;
    logic        tick_en;
    logic [15:0] setting;
    logic        pending;
    logic        applied;
    logic        clamped;
    logic        tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_frequency_controller dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .preset_sel_i        (preset_sel),
        .custom_en_i         (custom_en),
        .custom_value_i      (custom_value),
        .load_i              (load),
        .i2c_busy_i          (busy),
        .tick_en_i           (tick_en),
        .frequency_setting_o (setting),
        .pending_o           (pending),
        .applied_o           (applied),
        .clamped_o           (clamped),
        .tick_o              (tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles between two consecutive tick pulses, -1 on timeout
    task automatic measure_period(output int p);
        int t0;
        p  = -1;
        t0 = -1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (tick) begin
                if (t0 < 0) t0 = i;
                else begin
                    p = i - t0;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        int p;
        rst = 1'b1; preset_sel = 2'd0; custom_en = 1'b0;
        custom_value = 16'h0; load = 1'b0; busy = 1'b0; tick_en = 1'b1;
        step(); step();
        n_vec++;
        if (setting !== 16'h0095 || pending !== 1'b0 || applied !== 1'b0 ||
            clamped !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset: set=%h pend=%b app=%b clamp=%b tick=%b, want 0095 0 0 0 0",
                     setting, pending, applied, clamped, tick);
        end
        rst = 1'b0;
        measure_period(p);
        n_vec++;
        if (p !== 150) begin
            n_err++;
            $display("FAIL reset_tick_period: got %0d, want 150", p);
        end
    endtask

    task automatic test_preset_load();
        int p;
        preset_sel = 2'd1; custom_en = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        n_vec++;
        if (pending !== 1'b1 || setting !== 16'h0095 || applied !== 1'b0) begin
            n_err++;
            $display("FAIL load_edge: pend=%b set=%h app=%b, want 1 0095 0",
                     pending, setting, applied);
        end
        step();
        n_vec++;
        if (setting !== 16'h0024 || applied !== 1'b1 || pending !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL apply_edge: set=%h app=%b pend=%b tick=%b, want 0024 1 0 0",
                     setting, applied, pending, tick);
        end
        step();
        n_vec++;
        if (applied !== 1'b0) begin
            n_err++;
            $display("FAIL applied_one_cycle: got %b, want 0", applied);
        end
        measure_period(p);
        n_vec++;
        if (p !== 37) begin
            n_err++;
            $display("FAIL preset1_period: got %0d, want 37", p);
        end
    endtask

    task automatic test_busy_hold();
        int bad = 0;
        busy = 1'b1; preset_sel = 2'd2; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pending !== 1'b1 || setting !== 16'h0024 || applied !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL busy_hold: %0d bad cycles, want 0 (last set=%h pend=%b)",
                     bad, setting, pending);
        end
        busy = 1'b0;
        step();
        n_vec++;
        if (setting !== 16'h000E || applied !== 1'b1 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL busy_release: set=%h app=%b pend=%b, want 000e 1 0",
                     setting, applied, pending);
        end
    endtask

    task automatic test_clamp();
        custom_en = 1'b1; custom_value = 16'h0001; load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (setting !== 16'h0003 || clamped !== 1'b1) begin
            n_err++;
            $display("FAIL clamp_low: set=%h clamp=%b, want 0003 1", setting, clamped);
        end
        custom_value = 16'h0095; load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (setting !== 16'h0095 || clamped !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_clear: set=%h clamp=%b, want 0095 0", setting, clamped);
        end
        custom_en = 1'b0; preset_sel = 2'd3; load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (setting !== 16'h0003 || clamped !== 1'b0) begin
            n_err++;
            $display("FAIL preset_at_min: set=%h clamp=%b, want 0003 0", setting, clamped);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        busy = 1'b1; custom_en = 1'b0; preset_sel = 2'd1; load = 1'b1;
        step();
        custom_en = 1'b1; custom_value = 16'h0200;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (applied) pulses++;
        end
        busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (applied) pulses++;
        end
        n_vec++;
        if (pulses != 1 || setting !== 16'h0200) begin
            n_err++;
            $display("FAIL last_wins: pulses=%0d set=%h, want 1 0200", pulses, setting);
        end
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (applied !== 1'b1 || setting !== 16'h0200) begin
            n_err++;
            $display("FAIL same_value_apply: app=%b set=%h, want 1 0200", applied, setting);
        end
        custom_en = 1'b0;
    endtask

    task automatic test_tick_disable();
        int ticks = 0;
        tick_en = 1'b0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (tick) ticks++;
        end
        n_vec++;
        if (ticks != 0) begin
            n_err++;
            $display("FAIL tick_disabled: %0d ticks, want 0", ticks);
        end
        tick_en = 1'b1;
    endtask

    task automatic test_reset_pending();
        int pulses = 0;
        busy = 1'b1; preset_sel = 2'd2; load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (pending !== 1'b1 || setting !== 16'h0200) begin
            n_err++;
            $display("FAIL pre_reset_pending: pend=%b set=%h, want 1 0200", pending, setting);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (setting !== 16'h0095 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: set=%h pend=%b, want 0095 0", setting, pending);
        end
        step();
        rst = 1'b0; busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (applied) pulses++;
        end
        n_vec++;
        if (pulses != 0 || pending !== 1'b0 || setting !== 16'h0095) begin
            n_err++;
            $display("FAIL discard_after_reset: pulses=%0d pend=%b set=%h, want 0 0 0095",
                     pulses, pending, setting);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; preset_sel = 2'd1; load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_vec++;
        if (setting !== 16'h0024 || applied !== 1'b1) begin
            n_err++;
            $display("FAIL first_edge_load: set=%h app=%b, want 0024 1", setting, applied);
        end
    endtask

    initial begin
        test_reset();
        test_preset_load();
        test_busy_hold();
        test_clamp();
        test_back_to_back();
        test_tick_disable();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
